// File: rtl/srl_tap_reader_pkg.sv
// Shared types and constants for the addressable SRL delay line.
// SRL_TAP_READER_OREG_EN selects the two-cycle read latency.
package srl_tap_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } fill_state_t;

  function automatic int calcAw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

`ifdef SRL_TAP_READER_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/srl_tap_reader_if.sv
// Shift/flush and tap-read request/response bundle for srl_tap_reader.
interface srl_tap_reader_if
  import srl_tap_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
);
  localparam int AW = calcAw(DEPTH);

  logic             shift_en;
  logic [WIDTH-1:0] din;
  logic             flush;
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;

  modport master (
    output shift_en, din, flush, rd_req, rd_addr,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  shift_en, din, flush, rd_req, rd_addr,
    output rd_valid, rd_data, rd_err
  );

endinterface

// File: rtl/srl_tap_reader_chain.sv
// Reset-less shift chain with a dynamic tap read mux; kept free of reset
// and init so it maps onto SRL primitives.
module srl_tap_reader_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] tap_q [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      tap_q[0] <= din_i;
      for (int k = 1; k < DEPTH; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    if ({1'b0, rd_addr_i} < DEPTH_V) begin
      rd_data_o = tap_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/srl_tap_reader.sv
// Addressable delay line: fill tracker FSM, tap read with error check.
// Define SRL_TAP_READER_OREG_EN for an extra output register stage.
module srl_tap_reader
  import srl_tap_reader_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = calcAw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  srl_tap_reader_if.slave   bus,
  output logic [AW:0]       fill_o,
  output logic              full_o
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  if (DEPTH < 2) begin : g_depth_check
    $error("srl_tap_reader: DEPTH must be at least 2");
  end

  fill_state_t      state_q;
  logic [AW:0]      fill_q;
  logic             rspValid_q;
  logic [WIDTH-1:0] rspData_q;
  logic             rspErr_q;
  logic [WIDTH-1:0] tapData;
  logic             rspErr_d;
  logic [WIDTH-1:0] rspData_d;

  srl_tap_reader_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_chain (
    .clk        (clk),
    .shift_en_i (bus.shift_en),
    .din_i      (bus.din),
    .rd_addr_i  (bus.rd_addr),
    .rd_data_o  (tapData)
  );

  // Uses the pre-shift fill and taps, so a same-edge shift is not visible.
  assign rspErr_d  = ({1'b0, bus.rd_addr} >= fill_q) || ({1'b0, bus.rd_addr} >= DEPTH_V);
  assign rspData_d = rspErr_d ? '0 : tapData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      fill_q     <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      rspValid_q <= bus.rd_req;
      rspErr_q   <= bus.rd_req && rspErr_d;
      rspData_q  <= bus.rd_req ? rspData_d : '0;

      if (bus.flush) begin
        state_q <= EMPTY;
        fill_q  <= '0;
      end else if (bus.shift_en) begin
        case (state_q)
          EMPTY: begin
            state_q <= FILLING;
            fill_q  <= (AW+1)'(1);
          end
          FILLING: begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == DEPTH_V - 1'b1) begin
              state_q <= FULL;
            end
          end
          default: begin
            state_q <= FULL;
            fill_q  <= DEPTH_V;
          end
        endcase
      end
    end
  end

`ifdef SRL_TAP_READER_OREG_EN
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic             outErr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outErr_q   <= 1'b0;
    end else begin
      outValid_q <= rspValid_q;
      outData_q  <= rspData_q;
      outErr_q   <= rspErr_q;
    end
  end

  assign bus.rd_valid = outValid_q;
  assign bus.rd_data  = outData_q;
  assign bus.rd_err   = outErr_q;
`else
  assign bus.rd_valid = rspValid_q;
  assign bus.rd_data  = rspData_q;
  assign bus.rd_err   = rspErr_q;
`endif

  assign fill_o = fill_q;
  assign full_o = (fill_q == DEPTH_V);

endmodule

// File: tb/tb_srl_tap_reader.sv
// Bench for srl_tap_reader: queue-based reference model checked every cycle
// plus directed literal checks of the fill, read and reset behaviour.
module tb_srl_tap_reader;
  import srl_tap_reader_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = calcAw(DEPTH);

  typedef struct {
    bit               v;
    bit               e;
    logic [WIDTH-1:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [AW:0] fill;
  logic        full;
  bit          checkEn = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] hist[$];
  int               mFill = 0;
  rsp_t             pipe[RD_LAT];

  srl_tap_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  srl_tap_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .fill_o (fill),
    .full_o (full)
  );

  always #5 clk = ~clk;

  // Reference model: history queue newest-first, saturating fill count,
  // responses delayed through a RD_LAT-deep pipe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mFill = 0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] = '{v: 1'b0, e: 1'b0, d: '0};
    end else begin
      rsp_t r;
      int   a;
      r = '{v: 1'b0, e: 1'b0, d: '0};
      a = int'(bus.rd_addr);
      if (bus.rd_req) begin
        r.v = 1'b1;
        if (a >= mFill || a >= DEPTH) r.e = 1'b1;
        else r.d = hist[a];
      end
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = r;
      if (bus.shift_en) begin
        hist.push_front(bus.din);
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
      if (bus.flush) mFill = 0;
      else if (bus.shift_en && mFill < DEPTH) mFill = mFill + 1;
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn && !rst) begin
      checkOutput("model.rd_valid", 32'(bus.rd_valid), 32'(pipe[RD_LAT-1].v));
      checkOutput("model.rd_err",   32'(bus.rd_err),   32'(pipe[RD_LAT-1].e));
      checkOutput("model.rd_data",  32'(bus.rd_data),  32'(pipe[RD_LAT-1].d));
      checkOutput("model.fill",     32'(fill),         32'(mFill));
      checkOutput("model.full",     32'(full),         32'(mFill == DEPTH));
    end
  end

  task automatic applyStimulus(bit sh, logic [WIDTH-1:0] d, bit fl, bit rq, int addr);
    bus.shift_en = sh;
    bus.din      = d;
    bus.flush    = fl;
    bus.rd_req   = rq;
    bus.rd_addr  = AW'(addr);
    @(posedge clk);
    #1;
    bus.shift_en = 1'b0;
    bus.din      = '0;
    bus.flush    = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    @(negedge clk);
  endtask

  task automatic readCheck(string name, int addr, bit expErr, logic [WIDTH-1:0] expData);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, addr);
    for (int i = 1; i < RD_LAT; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
    checkOutput({name, ".valid"}, 32'(bus.rd_valid), 32'd1);
    checkOutput({name, ".err"},   32'(bus.rd_err),   32'(expErr));
    checkOutput({name, ".data"},  32'(bus.rd_data),  32'(expData));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.shift_en = 1'b0;
    bus.din      = '0;
    bus.flush    = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkEn = 1'b1;

    // 1: empty chain reads as error
    checkOutput("t1.fill",  32'(fill), 32'd0);
    checkOutput("t1.full",  32'(full), 32'd0);
    readCheck("t1.rd0", 0, 1'b1, 8'h00);

    // 2: three shifts, back-to-back reads
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 0);
    checkOutput("t2.fill", 32'(fill), 32'd3);
    for (int a = 0; a < 3; a++) applyStimulus(1'b0, '0, 1'b0, 1'b1, a);
    for (int i = 0; i < RD_LAT; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
    readCheck("t2.rd1", 1, 1'b0, 8'h22);
    readCheck("t2.rd3", 3, 1'b1, 8'h00);

    // 3: overfill saturates at DEPTH
    for (int v = 0; v < 40; v++) applyStimulus(1'b1, WIDTH'(v), 1'b0, 1'b0, 0);
    checkOutput("t3.fill", 32'(fill), 32'd32);
    checkOutput("t3.full", 32'(full), 32'd1);
    readCheck("t3.rd31", 31, 1'b0, 8'h08);
    readCheck("t3.rd0",  0,  1'b0, 8'h27);

    // 4: read during shift returns the pre-shift tap
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 0);
    for (int i = 1; i < RD_LAT; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
    checkOutput("t4.same.data", 32'(bus.rd_data), 32'h55);
    readCheck("t4.after", 0, 1'b0, 8'hAA);

    // 5: flush wins over shift for the count
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 0);
    checkOutput("t5.fill", 32'(fill), 32'd0);
    checkOutput("t5.full", 32'(full), 32'd0);
    readCheck("t5.rd0", 0, 1'b1, 8'h00);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 0);
    checkOutput("t5.fill1", 32'(fill), 32'd1);
    readCheck("t5.rd0b", 0, 1'b0, 8'h99);

    // 6: async reset drops the pending response
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 0);
    for (int i = 1; i < RD_LAT; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 0);
    checkOutput("t6.pre.valid", 32'(bus.rd_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6.rst.valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("t6.rst.fill",  32'(fill),         32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    readCheck("t6.stale", 0, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
